mem_master: RTL and testbench

//   Initiator-side sequencer for the single-port memory block. Accepts one read/write request at a time

---
 rtl/tiny16_mem_pkg.sv | 23 ++
 rtl/mem_master_if.sv | 25 ++
 rtl/mem_master.sv | 115 +++++++++++
 tb/tb_mem_master.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny16_mem_pkg.sv
// Shared types and default widths for the tiny16 single-port memory and its initiator.
// Also reused by the memory block's own tests.
package tiny16_mem_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WR,
    ST_RD,
    ST_CAPT,
    ST_RESP
  } mem_master_state_t;

  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_master_if.sv
// Request/response handshake between an initiator (CPU load/store path or fetch) and mem_master.
interface mem_master_if
  import tiny16_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_master.sv
// Initiator-side sequencer driving the single-port memory's addr/in/out enable phases.
// Optional MEM_MASTER_ADDR_SKIP_EN: skip the ADDR phase when the address is already latched.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// ADDR  | mem_addr_en pulse, memory latches address
// WR    | mem_in_en pulse, memory writes mem_in
// RD    | mem_out_en pulse, memory registers read data
// CAPT  | read data on mem_out, captured into rsp_rdata
// RESP  | rsp_valid pulse
module mem_master
  import tiny16_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  mem_master_if.slave       bus,
  output logic              mem_addr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_in_en,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_out_en,
  input  logic [DATA_W-1:0] mem_out
);

  mem_master_state_t state;
  logic              wr_q;
`ifdef MEM_MASTER_ADDR_SKIP_EN
  logic [ADDR_W-1:0] last_addr;
  logic              last_valid;
`endif

  // All outputs are registered alongside the state so they are glitch-free Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wr_q          <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      mem_addr_en   <= 1'b0;
      mem_in_en     <= 1'b0;
      mem_out_en    <= 1'b0;
      mem_addr      <= '0;
      mem_in        <= '0;
`ifdef MEM_MASTER_ADDR_SKIP_EN
      last_addr     <= '0;
      last_valid    <= 1'b0;
`endif
    end else begin
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      mem_addr_en   <= 1'b0;
      mem_in_en     <= 1'b0;
      mem_out_en    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            mem_addr <= bus.req_addr;
            wr_q     <= bus.req_write;
            if (bus.req_write) mem_in <= bus.req_wdata;
`ifdef MEM_MASTER_ADDR_SKIP_EN
            // Memory still holds this address from the last ADDR phase.
            if (last_valid && (bus.req_addr == last_addr)) begin
              state      <= bus.req_write ? ST_WR : ST_RD;
              mem_in_en  <= bus.req_write;
              mem_out_en <= !bus.req_write;
            end else begin
              state       <= ST_ADDR;
              mem_addr_en <= 1'b1;
            end
`else
            state       <= ST_ADDR;
            mem_addr_en <= 1'b1;
`endif
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        ST_ADDR: begin
          state      <= wr_q ? ST_WR : ST_RD;
          mem_in_en  <= wr_q;
          mem_out_en <= !wr_q;
`ifdef MEM_MASTER_ADDR_SKIP_EN
          last_addr  <= mem_addr;
          last_valid <= 1'b1;
`endif
        end
        ST_WR: begin
          state         <= ST_RESP;
          bus.rsp_valid <= 1'b1;
        end
        ST_RD: begin
          state <= ST_CAPT;
        end
        ST_CAPT: begin
          state         <= ST_RESP;
          bus.rsp_rdata <= mem_out;
          bus.rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a behavioural single-port memory attached.
// Builds with or without MEM_MASTER_ADDR_SKIP_EN; expected latencies follow the macro.
module tb_mem_master;
  import tiny16_mem_pkg::*;

  typedef struct {
    mem_req_t    req;
    logic [15:0] exp_rdata;
    string       name;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        mem_addr_en;
  logic [15:0] mem_addr;
  logic        mem_in_en;
  logic [15:0] mem_in;
  logic        mem_out_en;
  logic [15:0] mem_out;

  mem_master_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_master #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mem_addr_en (mem_addr_en),
    .mem_addr    (mem_addr),
    .mem_in_en   (mem_in_en),
    .mem_in      (mem_in),
    .mem_out_en  (mem_out_en),
    .mem_out     (mem_out)
  );

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] mem_lat;

  bit          mdl_valid = 0;
  logic [15:0] mdl_addr  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_addr_en) mem_lat <= mem_addr;
    if (mem_in_en) mem[mem_lat] <= mem_in;
    if (mem_out_en) mem_out <= mem[mem_lat];
  end

  always @(posedge clk) begin
    if (!rst && bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // At most one memory enable per cycle, checked every cycle.
  always @(negedge clk) begin
    if (!rst) check(32'(($countones({mem_addr_en, mem_in_en, mem_out_en}) <= 1)), 32'd1, "en_onehot");
  end

  function automatic int model_lat(input bit wr, input logic [15:0] addr, output bit skip);
`ifdef MEM_MASTER_ADDR_SKIP_EN
    skip = mdl_valid && (addr == mdl_addr);
`else
    skip = 1'b0;
`endif
    if (!skip) begin
      mdl_valid = 1'b1;
      mdl_addr  = addr;
    end
    return (wr ? 3 : 4) - (skip ? 1 : 0);
  endfunction

  task automatic do_txn(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input string name);
    int exp_lat, lat, a_cyc, i_cyc, o_cyc;
    bit skip;
    logic [15:0] rd_before;
    exp_lat   = model_lat(wr, addr, skip);
    rd_before = bus.rsp_rdata;
    check(32'(bus.req_ready), 32'd1, {name, "_ready_in"});
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0; a_cyc = 0; i_cyc = 0; o_cyc = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      if (mem_addr_en && a_cyc == 0) begin
        a_cyc = c;
        check(32'(mem_addr), 32'(addr), {name, "_mem_addr"});
      end
      if (mem_in_en && i_cyc == 0) begin
        i_cyc = c;
        check(32'(mem_in), 32'(wd), {name, "_mem_in"});
      end
      if (mem_out_en && o_cyc == 0) o_cyc = c;
      if (bus.rsp_valid) lat = c;
      else @(negedge clk);
    end
    check(32'(lat), 32'(exp_lat), {name, "_latency"});
    check(32'(a_cyc), skip ? 32'd0 : 32'd1, {name, "_addr_en_cycle"});
    if (wr) begin
      check(32'(i_cyc), 32'(exp_lat - 1), {name, "_in_en_cycle"});
      check(32'(o_cyc), 32'd0, {name, "_out_en_cycle"});
      check(32'(bus.rsp_rdata), 32'(rd_before), {name, "_rdata_held"});
    end else begin
      check(32'(o_cyc), 32'(exp_lat - 2), {name, "_out_en_cycle"});
      check(32'(i_cyc), 32'd0, {name, "_in_en_cycle"});
      check(32'(bus.rsp_rdata), 32'(exp_rd), {name, "_rdata"});
    end
    @(negedge clk);
    check(32'(bus.rsp_valid), 32'd0, {name, "_rsp_one_cycle"});
    check(32'(bus.req_ready), 32'd1, {name, "_ready_after"});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_valid = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    int lat1, lat2, got, c, acc0;
    bit sk, seen_rsp, seen_out;
    logic [15:0] rd_hold;

    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat1, lat2, got, cyc, acc0;
    bit sk, seen_rsp, seen_out;

    vecs[0] = '{'{1'b1, 16'h0000, 16'h1234}, 16'h0000, "wr_0000"};
    vecs[1] = '{'{1'b1, 16'h0001, 16'h4321}, 16'h0000, "wr_0001"};
    vecs[2] = '{'{1'b0, 16'h0000, 16'h0000}, 16'h1234, "rd_0000"};
    vecs[3] = '{'{1'b0, 16'h0001, 16'h0000}, 16'h4321, "rd_0001"};
    vecs[4] = '{'{1'b1, 16'h0005, 16'hBEEF}, 16'h0000, "wr_0005"};
    vecs[5] = '{'{1'b0, 16'h0005, 16'h0000}, 16'hBEEF, "rd_0005"};
    vecs[6] = '{'{1'b1, 16'hFFFF, 16'hA5A5}, 16'h0000, "wr_ffff"};
    vecs[7] = '{'{1'b0, 16'hFFFF, 16'h0000}, 16'hA5A5, "rd_ffff"};
    vecs[8] = '{'{1'b1, 16'h0002, 16'h7777}, 16'h0000, "wr_0002"};
    vecs[9] = '{'{1'b0, 16'h0000, 16'h0000}, 16'h1234, "rd_0000b"};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    check(32'(bus.req_ready), 32'd1, "rst_req_ready");
    check(32'(bus.rsp_valid), 32'd0, "rst_rsp_valid");
    check(32'(bus.rsp_rdata), 32'd0, "rst_rsp_rdata");
    check(32'({mem_addr_en, mem_in_en, mem_out_en}), 32'd0, "rst_enables");
    check(32'(mem_addr), 32'd0, "rst_mem_addr");
    check(32'(mem_in), 32'd0, "rst_mem_in");

    for (int i = 0; i < 10; i++)
      do_txn(vecs[i].req.write, vecs[i].req.addr, vecs[i].req.wdata, vecs[i].exp_rdata, vecs[i].name);

    // Back-to-back: second request held valid during a read.
    acc0 = acc_cnt;
    lat1 = model_lat(1'b0, 16'h0000, sk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    bus.req_addr = 16'h0001;
    got = 0;
    cyc = 1;
    while (cyc <= 10 && !bus.req_ready) begin
      if (bus.rsp_valid) begin
        got = cyc;
        check(32'(bus.rsp_rdata), 32'h1234, "hold_first_rdata");
      end
      @(negedge clk);
      cyc++;
    end
    check(32'(got), 32'(lat1), "hold_first_latency");
    check(32'(cyc), 32'(lat1 + 1), "hold_ready_cycle");
    lat2 = model_lat(1'b0, 16'h0001, sk);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    got = 0;
    for (int c2 = 1; c2 <= 10 && got == 0; c2++) begin
      if (bus.rsp_valid) got = c2;
      else @(negedge clk);
    end
    check(32'(got), 32'(lat2), "hold_second_latency");
    check(32'(bus.rsp_rdata), 32'h4321, "hold_second_rdata");
    repeat (3) @(negedge clk);
    check(32'(acc_cnt - acc0), 32'd2, "hold_accept_count");

    // Reset in the RD cycle of a read @0x0002.
    lat1 = model_lat(1'b0, 16'h0002, sk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    seen_out = 1'b0;
    for (int c3 = 1; c3 <= 6 && !seen_out; c3++) begin
      if (mem_out_en) seen_out = 1'b1;
      else @(negedge clk);
    end
    check(32'(seen_out), 32'd1, "rstmid_reached_rd");
    rst = 1'b1;
    @(negedge clk);
    check(32'({mem_addr_en, mem_in_en, mem_out_en}), 32'd0, "rstmid_enables");
    check(32'(bus.rsp_valid), 32'd0, "rstmid_rsp_valid");
    rst = 1'b0;
    mdl_valid = 1'b0;
    seen_rsp = 1'b0;
    repeat (5) begin
      if (bus.rsp_valid) seen_rsp = 1'b1;
      @(negedge clk);
    end
    check(32'(seen_rsp), 32'd0, "rstmid_no_rsp");
    do_txn(1'b0, 16'h0002, 16'h0000, 16'h7777, "rd_0002_after_rst");

    // After reset the tracked address is forgotten: first read re-latches, second may skip.
    do_reset();
    do_txn(1'b0, 16'h0005, 16'h0000, 16'hBEEF, "rd_0005_post_rst");
    do_txn(1'b0, 16'h0005, 16'h0000, 16'hBEEF, "rd_0005_repeat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
